// File: rtl/transient_generator_pkg.sv
// Shared definitions for the single-wire state interface: FSM encoding,
// configuration field widths and line polarity constants.
package transient_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int CFG_W = 4;
   localparam int PH_W  = 5;

   localparam logic POL_ACTIVE_LOW  = 1'b0;
   localparam logic POL_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/transient_generator_tick_prescaler.sv
// Free-running tick divider: o_tick is high on the last cycle of every
// PRESCALE-cycle period. i_clear restarts the period from zero.
module tick_prescaler #(
   parameter int PRESCALE = 100
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign o_tick = (cnt == LAST);

   // Count 0..PRESCALE-1, wrapping on the tick or restarting on clear.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/transient_generator.sv
// Burst generator for the state_monitor input line: N invalid-level pulses
// of W ticks, each followed by a valid-level gap of G ticks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line follows i_polarity, waiting for i_start
// ST_PULSE | line held at invalid level (~pol) for W ticks
// ST_GAP   | line held at valid level (pol) for G ticks, then next pulse
module transient_generator
   import transient_gen_pkg::*;
#(
   parameter int PRESCALE = 100
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_polarity,
   input  logic [CFG_W-1:0] i_count,
   input  logic [CFG_W-1:0] i_width,
   input  logic [CFG_W-1:0] i_gap,
   output logic             o_signal,
   output logic             o_busy,
   output logic             o_done
);

   state_t          state;
   logic            pol;
   logic [PH_W-1:0] w_last;
   logic [PH_W-1:0] g_last;
   logic [PH_W-1:0] rem;
   logic [PH_W-1:0] ph_cnt;
   logic            tick;
   logic            phase_end;
   logic            clear;

   // A phase ends on the tick that completes its final tick period.
   assign phase_end = tick && (((state == ST_PULSE) && (ph_cnt == w_last)) ||
                               ((state == ST_GAP)   && (ph_cnt == g_last)));

   // Realign the time base on burst start and every phase boundary.
   assign clear = ((state == ST_IDLE) && i_start) || phase_end;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (clear),
      .o_tick  (tick)
   );

   // Sequencer: latches config at start, walks pulse/gap phases.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         pol      <= 1'b0;
         w_last   <= '0;
         g_last   <= '0;
         rem      <= '0;
         ph_cnt   <= '0;
         o_signal <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_done   <= 1'b0;
               o_signal <= i_polarity;
               if (i_start) begin
                  pol      <= i_polarity;
                  rem      <= PH_W'(i_count) + PH_W'(1);
                  w_last   <= PH_W'(i_width);
                  g_last   <= PH_W'(i_gap);
                  ph_cnt   <= '0;
                  o_signal <= ~i_polarity;
                  o_busy   <= 1'b1;
                  state    <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (tick) begin
                  if (ph_cnt == w_last) begin
                     ph_cnt   <= '0;
                     o_signal <= pol;
                     state    <= ST_GAP;
                  end else begin
                     ph_cnt <= ph_cnt + PH_W'(1);
                  end
               end
            end
            ST_GAP: begin
               if (tick) begin
                  if (ph_cnt == g_last) begin
                     ph_cnt <= '0;
                     if (rem > PH_W'(1)) begin
                        rem      <= rem - PH_W'(1);
                        o_signal <= ~pol;
                        state    <= ST_PULSE;
                     end else begin
                        o_signal <= pol;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        state    <= ST_IDLE;
                     end
                  end else begin
                     ph_cnt <= ph_cnt + PH_W'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
